// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO port: register byte offsets and default parameter values.
package gpio_pkg;

    localparam int DEF_SW_W      = 8;
    localparam int DEF_LED_W     = 8;
    localparam int DEF_DB_CYCLES = 4;

    localparam logic [3:0] OFS_SW_DATA   = 4'h0;
    localparam logic [3:0] OFS_LED       = 4'h4;
    localparam logic [3:0] OFS_EDGE_STAT = 4'h8;
    localparam logic [3:0] OFS_IRQ_MASK  = 4'hC;

    // Word select for a byte offset; the low two address bits never take part in decode.
    function automatic logic [1:0] reg_index(input logic [3:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One switch bit: 2-flop synchronizer followed by a stability-count debouncer.
// 'changed' pulses in the same cycle the debounced output takes its new value.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic Clk,
    input  logic Rst,
    input  logic din,
    output logic dout,
    output logic changed
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        changed = 1'b0;
        // The counter holds how many cycles in a row the synced level has disagreed.
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d    = sync2_q;
                changed = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = db_q;

endmodule

// File: rtl/gpio_io_port.sv
// Memory-mapped GPIO port: debounced switches, LED register, edge status and interrupt.
// Edge status, interrupt mask and Irq exist only when GPIO_IRQ_EN is defined.
module gpio_io_port
    import gpio_pkg::*;
#(
    parameter int SW_W      = DEF_SW_W,
    parameter int LED_W     = DEF_LED_W,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [SW_W-1:0]  Switch,
    output logic [LED_W-1:0] Led,
    input  logic [3:0]       Addr,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    output logic             Irq
);

    localparam logic [1:0] SEL_SW_DATA   = reg_index(OFS_SW_DATA);
    localparam logic [1:0] SEL_LED       = reg_index(OFS_LED);
    localparam logic [1:0] SEL_EDGE_STAT = reg_index(OFS_EDGE_STAT);
    localparam logic [1:0] SEL_IRQ_MASK  = reg_index(OFS_IRQ_MASK);

    logic [SW_W-1:0] sw_db;
    logic [SW_W-1:0] sw_changed;
    logic [SW_W-1:0] edge_stat;
    logic [SW_W-1:0] irq_mask;
    logic [1:0]      reg_sel;

    assign reg_sel = Addr[3:2];

    for (genvar gi = 0; gi < SW_W; gi++) begin : g_db
        gpio_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .Clk     (Clk),
            .Rst     (Rst),
            .din     (Switch[gi]),
            .dout    (sw_db[gi]),
            .changed (sw_changed[gi])
        );
    end

`ifdef GPIO_IRQ_EN
    logic [SW_W-1:0] edge_q, edge_d;
    logic [SW_W-1:0] mask_q, mask_d;
    logic            irq_q, irq_d;

    always_comb begin
        edge_d = edge_q;
        mask_d = mask_q;
        if (MemWrite && reg_sel == SEL_EDGE_STAT) begin
            edge_d = edge_q & ~WriteData[SW_W-1:0];
        end
        // OR-ing the set last lets a fresh edge survive a same-cycle clear.
        edge_d = edge_d | sw_changed;
        if (MemWrite && reg_sel == SEL_IRQ_MASK) begin
            mask_d = WriteData[SW_W-1:0];
        end
        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            edge_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            edge_q <= edge_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign edge_stat = edge_q;
    assign irq_mask  = mask_q;
    assign Irq       = irq_q;
`else
    logic unused_changed;

    assign edge_stat      = '0;
    assign irq_mask       = '0;
    assign Irq            = 1'b0;
    assign unused_changed = ^sw_changed;
`endif

    logic             unused_bus;
    logic [LED_W-1:0] led_q, led_d;
    logic [31:0]      rd_q, rd_d;

    assign unused_bus = ^{Addr[1:0], WriteData};

    always_comb begin
        led_d = led_q;
        if (MemWrite && reg_sel == SEL_LED) begin
            led_d = WriteData[LED_W-1:0];
        end
        // Reads sample the registers before this edge's write lands.
        rd_d = rd_q;
        if (MemRead) begin
            rd_d = '0;
            case (reg_sel)
                SEL_SW_DATA:   rd_d[SW_W-1:0]  = sw_db;
                SEL_LED:       rd_d[LED_W-1:0] = led_q;
                SEL_EDGE_STAT: rd_d[SW_W-1:0]  = edge_stat;
                SEL_IRQ_MASK:  rd_d[SW_W-1:0]  = irq_mask;
                default:       rd_d            = '0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            led_q <= '0;
            rd_q  <= '0;
        end else begin
            led_q <= led_d;
            rd_q  <= rd_d;
        end
    end

    assign Led      = led_q;
    assign ReadData = rd_q;

endmodule

// File: tb/tb_gpio_io_port.sv
// Bench for gpio_io_port: register table, directed debounce/IRQ sequences, then random traffic
// checked against a history-based model. Expectations follow GPIO_IRQ_EN as compiled.
module tb_gpio_io_port;

    localparam int SW_W  = 8;
    localparam int LED_W = 8;
    localparam int DB    = 4;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [SW_W-1:0]  Switch = '0;
    logic [LED_W-1:0] Led;
    logic [3:0]       Addr = '0;
    logic             MemWrite = 1'b0;
    logic             MemRead = 1'b0;
    logic [31:0]      WriteData = '0;
    logic [31:0]      ReadData;
    logic             Irq;

    int n_tests = 0;
    int n_fail  = 0;

    gpio_io_port #(
        .SW_W      (SW_W),
        .LED_W     (LED_W),
        .DB_CYCLES (DB)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Switch    (Switch),
        .Led       (Led),
        .Addr      (Addr),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Irq       (Irq)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: a debounced bit flips once the switch level seen two edges late has
    // disagreed with it on each of the last DB edges.
    logic [SW_W-1:0]  hist [0:DB+1];
    logic [SW_W-1:0]  m_db = '0, m_edge = '0, m_mask = '0;
    logic [LED_W-1:0] m_led = '0;
    logic [31:0]      m_rd = '0;
    logic             m_irq = 1'b0;

    task automatic model_step();
        logic [SW_W-1:0] chg;
        logic [31:0]     rdv;
        if (Rst) begin
            for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
            m_db = '0; m_edge = '0; m_mask = '0; m_led = '0; m_rd = '0; m_irq = 1'b0;
            return;
        end
        for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = Switch;
        chg = '0;
        for (int b = 0; b < SW_W; b++) begin
            bit all_diff = 1'b1;
            for (int k = 0; k < DB; k++) if (hist[2+k][b] == m_db[b]) all_diff = 1'b0;
            chg[b] = all_diff;
        end
        if (MemRead) begin
            case (Addr[3:2])
                2'd0:    rdv = 32'(m_db);
                2'd1:    rdv = 32'(m_led);
                2'd2:    rdv = IRQ_EN ? 32'(m_edge) : 32'd0;
                default: rdv = IRQ_EN ? 32'(m_mask) : 32'd0;
            endcase
            m_rd = rdv;
        end
        m_irq = IRQ_EN && ((m_edge & m_mask) != 0);
        if (IRQ_EN) begin
            if (MemWrite && Addr[3:2] == 2'd2) m_edge = m_edge & ~WriteData[SW_W-1:0];
            m_edge = m_edge | chg;
            if (MemWrite && Addr[3:2] == 2'd3) m_mask = WriteData[SW_W-1:0];
        end
        if (MemWrite && Addr[3:2] == 2'd1) m_led = WriteData[LED_W-1:0];
        m_db = m_db ^ chg;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        Addr = a; MemRead = 1'b1;
        tick();
        MemRead = 1'b0;
        d = ReadData;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d);
        Addr = a; WriteData = d; MemWrite = 1'b1;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        bit          we;
        bit          re;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  exp_led;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic [31:0] rd;
        logic [31:0] irq_exp;

        vecs[0]  = '{0, 1, 4'h0, 32'h0,         8'h00, 32'h0};
        vecs[1]  = '{0, 1, 4'h4, 32'h0,         8'h00, 32'h0};
        vecs[2]  = '{0, 1, 4'h8, 32'h0,         8'h00, 32'h0};
        vecs[3]  = '{0, 1, 4'hC, 32'h0,         8'h00, 32'h0};
        vecs[4]  = '{1, 0, 4'h4, 32'h123456A5,  8'hA5, 32'h0};
        vecs[5]  = '{0, 1, 4'h5, 32'h0,         8'hA5, 32'hA5};
        vecs[6]  = '{1, 1, 4'h4, 32'h3C,        8'h3C, 32'hA5};
        vecs[7]  = '{0, 1, 4'h4, 32'h0,         8'h3C, 32'h3C};
        vecs[8]  = '{1, 0, 4'h0, 32'hFF,        8'h3C, 32'h3C};
        vecs[9]  = '{0, 1, 4'h0, 32'h0,         8'h3C, 32'h0};
        vecs[10] = '{1, 0, 4'hC, 32'hFFFFFF03,  8'h3C, 32'h0};
        vecs[11] = '{1, 1, 4'hC, 32'h05,        8'h3C, IRQ_EN ? 32'h03 : 32'h0};
        vecs[12] = '{0, 1, 4'hC, 32'h0,         8'h3C, IRQ_EN ? 32'h05 : 32'h0};
        vecs[13] = '{1, 0, 4'hC, 32'h0,         8'h3C, IRQ_EN ? 32'h05 : 32'h0};
        vecs[14] = '{0, 1, 4'h8, 32'h0,         8'h3C, 32'h0};
        vecs[15] = '{0, 1, 4'h7, 32'h0,         8'h3C, 32'h3C};

        // Reset held three edges, Switch low.
        Rst = 1'b1;
        idle(3);
        Rst = 1'b0;
        check("reset_led", 32'(Led), 32'h0);
        check("reset_irq", 32'(Irq), 32'h0);
        check("reset_rdata", ReadData, 32'h0);

        foreach (vecs[i]) begin
            Addr = vecs[i].addr; WriteData = vecs[i].wdata;
            MemWrite = vecs[i].we; MemRead = vecs[i].re;
            tick();
            MemWrite = 1'b0; MemRead = 1'b0;
            check($sformatf("vec%0d_led", i), 32'(Led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_rdata", i), ReadData, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(Irq), 32'h0);
        end

        // Clean step: visible to a read capturing cycle 6, not cycle 5.
        Switch = 8'h5A;
        idle(5);
        do_read(4'h0, rd); check("step_sw_cycle5", rd, 32'h00);
        do_read(4'h0, rd); check("step_sw_cycle6", rd, 32'h5A);
        do_write(4'h8, 32'hFF);

        // Bit 0 bounces every 2 cycles, then settles high.
        for (int i = 0; i < 10; i++) begin
            Switch[0] = ~Switch[0];
            idle(2);
        end
        Switch[0] = 1'b1;
        idle(4);
        do_read(4'h8, rd); check("bounce_no_edge", rd, 32'h00);
        do_read(4'h0, rd); check("bounce_sw_cycle5", rd, 32'h5A);
        do_read(4'h0, rd); check("bounce_sw_cycle6", rd, 32'h5B);

        // Masked rising edge on bit 0 raises Irq; W1C drops it two edges later.
        Switch[0] = 1'b0;
        idle(8);
        do_write(4'h8, 32'hFF);
        do_write(4'hC, 32'h01);
        check("irq_idle", 32'(Irq), 32'h0);
        irq_exp = IRQ_EN ? 32'h1 : 32'h0;
        Switch[0] = 1'b1;
        idle(6);
        check("irq_not_early", 32'(Irq), 32'h0);
        do_read(4'h8, rd);
        check("edge_bit0", rd, IRQ_EN ? 32'h01 : 32'h0);
        check("irq_raised", 32'(Irq), irq_exp);
        do_write(4'h8, 32'h01);
        check("irq_after_w1c_1", 32'(Irq), irq_exp);
        tick();
        check("irq_after_w1c_2", 32'(Irq), 32'h0);

        // Clear of bit 3 lands in the same edge a new bit-3 edge is recorded.
        Switch[3] = 1'b0;
        idle(5);
        do_write(4'h8, 32'h08);
        do_read(4'h8, rd); check("set_beats_clear", rd, IRQ_EN ? 32'h08 : 32'h0);
        do_read(4'h0, rd); check("sw_after_fall", rd, 32'h53);

        // Reset beats a same-cycle LED write.
        do_write(4'h4, 32'h66);
        check("led_write", 32'(Led), 32'h66);
        Rst = 1'b1; Switch = 8'h00;
        do_write(4'h4, 32'hA5);
        Rst = 1'b0;
        check("led_reset_wins", 32'(Led), 32'h0);

        // Reset mid-debounce, switch still high afterwards: edge 2+DB edges after release.
        Switch = 8'h81;
        idle(4);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        idle(4);
        do_read(4'h0, rd); check("rst_mid_r5", rd, 32'h00);
        do_read(4'h0, rd); check("rst_mid_r6", rd, 32'h00);
        do_read(4'h0, rd); check("rst_mid_r7", rd, 32'h81);
        do_read(4'h8, rd); check("rst_mid_edge", rd, IRQ_EN ? 32'h81 : 32'h0);
        check("rst_mid_irq", 32'(Irq), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) Switch = Switch ^ 8'(1 << $urandom_range(0, 7));
            Rst       = ($urandom_range(0, 299) == 0);
            MemWrite  = ($urandom_range(0, 3) == 0);
            MemRead   = ($urandom_range(0, 2) == 0);
            Addr      = 4'($urandom);
            WriteData = $urandom;
            tick();
            check("rand_led", 32'(Led), 32'(m_led));
            check("rand_rdata", ReadData, m_rd);
            check("rand_irq", 32'(Irq), 32'(m_irq));
        end
        Rst = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_io_port.md
GPIO_IO_PORT -- requirements
Module: gpio_io_port

Interface
REQ-001 SHALL have parameter SW_W, default 8: switch input width, 1..32.
REQ-002 SHALL have parameter LED_W, default 8: LED output width, 1..32.
REQ-003 SHALL have parameter DB_CYCLES, default 4: debounce stability count, >=1.
REQ-004 SHALL have port Clk, input, 1: the only clock; all logic on rising edge.
REQ-005 SHALL have port Rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port Switch, input, SW_W: raw asynchronous switch levels.
REQ-007 SHALL have port Led, output, LED_W: LED drive, registered.
REQ-008 SHALL have port Addr, input, 4: byte address; Addr[3:2] selects the register, Addr[1:0] ignored.
REQ-009 SHALL have port MemWrite, input, 1: write strobe, one cycle per access.
REQ-010 SHALL have port MemRead, input, 1: read strobe.
REQ-011 SHALL have port WriteData, input, 32: write data.
REQ-012 SHALL have port ReadData, output, 32: read data, registered.
REQ-013 SHALL have port Irq, output, 1: level interrupt, registered.

Function
REQ-014 Register map SHALL be: 0x0 SW_DATA (RO), 0x4 LED (RW), 0x8 EDGE_STAT (W1C), 0xC IRQ_MASK (RW); bits above the field width read 0.
REQ-015 Each Switch bit SHALL pass a 2-flop synchronizer before any other use.
REQ-016 A debounced bit SHALL take the synced value only after the synced value has differed from it for DB_CYCLES consecutive cycles; any match resets that bit's counter to 0.
REQ-017 Switch-to-SW_DATA latency for a clean step SHALL be exactly 2 + DB_CYCLES cycles.
REQ-018 A debounced bit change in either direction SHALL set the matching EDGE_STAT bit in the same cycle the debounced value updates.
REQ-019 Writing 1 to an EDGE_STAT bit SHALL clear it; writing 0 SHALL leave it unchanged; if a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-020 Irq SHALL be registered |(EDGE_STAT & IRQ_MASK), one cycle after the term becomes true.
REQ-021 A LED write SHALL update Led on the next edge from WriteData[LED_W-1:0]; writes to SW_DATA SHALL be ignored.
REQ-022 ReadData SHALL be valid the cycle after MemRead and SHALL hold its value until the next read; a read and a write to the same address in one cycle SHALL return the pre-write value.
REQ-023 MemRead and MemWrite asserted together SHALL both be performed.

Reset
REQ-024 On Rst=1 at a clock edge: Led=0, ReadData=0, Irq=0, EDGE_STAT=0, IRQ_MASK=0, synchronizer flops=0, debounce counters=0, debounced values=0.
REQ-025 Reset SHALL override any same-cycle bus write; reset asserted mid-debounce SHALL discard the partial count.
REQ-026 Switch bits that are already high when reset is released SHALL produce an edge after 2 + DB_CYCLES cycles.

Configuration
REQ-027 Macro GPIO_IRQ_EN defined: EDGE_STAT, IRQ_MASK and Irq SHALL be implemented as specified above.
REQ-028 GPIO_IRQ_EN undefined: EDGE_STAT and IRQ_MASK SHALL read 0 and ignore writes, Irq SHALL be tied to 0, and no edge or mask flops SHALL be synthesized.

Structure
REQ-029 Package gpio_pkg SHALL hold the register offset constants (0x0/0x4/0x8/0xC) and the default parameter values.
REQ-030 Per-bit synchronizer and debounce logic SHALL be sub-module gpio_debounce (ports Clk, Rst, din, dout, changed), instantiated SW_W times by a generate loop.
REQ-031 The debounce counter width SHALL be $clog2(DB_CYCLES+1).

Verification (defaults, GPIO_IRQ_EN defined unless stated)
REQ-032 Rst held 3 cycles, then released with Switch=0 -> Led=0, Irq=0, reads of all four registers return 0.
REQ-033 Switch 0x00->0x5A held steady -> SW_DATA reads 0x5A from cycle 6 after the step, and reads 0x00 at cycle 5.
REQ-034 Switch bit 0 toggles every 2 cycles for 20 cycles, then settles to 1 -> no change to SW_DATA bit 0 and no EDGE_STAT[0] during the toggling; update 6 cycles after the final settle.
REQ-035 IRQ_MASK=0x01, Switch[0] rises -> EDGE_STAT=0x01 and Irq=1 one cycle later; a W1C of 0x01 to 0x8 -> Irq=0 after 2 cycles.
REQ-036 W1C to EDGE_STAT bit 3 in the same cycle a new bit-3 edge is detected -> EDGE_STAT[3] stays 1.
REQ-037 Write 0xA5 to LED with Rst=1 in the same cycle -> Led=0; with GPIO_IRQ_EN undefined, a Switch step -> Irq stays 0 and EDGE_STAT reads 0.
